// File: rtl/blade_pool.sv
// Pool of NUM_SLOTS player blades: edge-triggered fire with cooldown, lowest-free-slot
// allocation, per-slot motion, bounds/lifetime/collision despawn and saturated speed.
module blade_pool #(
    parameter int NUM_SLOTS    = 4,
    parameter int X_MIN        = 144,
    parameter int X_MAX        = 783,
    parameter int X_OFFSET     = 40,
    parameter int Y_OFFSET     = 8,
    parameter int BLADE_W      = 28,
    parameter int SPEED_OFFSET = 8,
    parameter int COOLDOWN     = 10,
    parameter int LIFETIME     = 64
) (
    input  logic                   sim_clk,
    input  logic                   reset_n,
    input  logic                   shoot,
    input  logic [9:0]             player_xPos,
    input  logic [9:0]             player_yPos,
    input  logic [4:0]             player_xSpeed,
    input  logic                   player_xDir,
    input  logic [NUM_SLOTS-1:0]   bladeCol,
    output logic [27*NUM_SLOTS-1:0] bladeState,
    output logic                   fire_ack,
    output logic                   pool_full
);

    localparam logic [10:0] X_MIN_W     = 11'(X_MIN);
    localparam logic [10:0] X_MAX_W     = 11'(X_MAX);
    localparam logic [7:0]  COOLDOWN_W  = 8'(COOLDOWN);
    localparam logic [7:0]  LIFE_LAST   = 8'(LIFETIME - 1);

    typedef enum logic {IDLE = 1'b0, MOVE = 1'b1} slotState_t;

    logic                 shootQReg;
    logic [7:0]           cooldownReg;
    logic                 shootReq;
    logic                 accept;
    logic [NUM_SLOTS-1:0] activeVec;
    logic [NUM_SLOTS-1:0] grant;
    logic [NUM_SLOTS:0]   busyBelow;

    logic [9:0] spawnX;
    logic [9:0] spawnY;
    logic [5:0] spawnSpeedSum;
    logic [4:0] spawnSpeed;

    assign pool_full = &activeVec;
    assign shootReq  = shoot & ~shootQReg;
    assign accept    = shootReq & (cooldownReg == 8'd0) & ~pool_full;

    assign spawnX        = player_xDir ? (player_xPos + 10'(X_OFFSET))
                                       : (player_xPos - 10'(X_OFFSET) - 10'(BLADE_W));
    assign spawnY        = player_yPos - 10'(Y_OFFSET);
    assign spawnSpeedSum = {1'b0, player_xSpeed} + 6'(SPEED_OFFSET);
    assign spawnSpeed    = spawnSpeedSum[5] ? 5'd31 : spawnSpeedSum[4:0];

    always_ff @(posedge sim_clk) begin
        if (!reset_n) begin
            shootQReg   <= 1'b0;
            cooldownReg <= 8'd0;
            fire_ack    <= 1'b0;
        end else begin
            shootQReg <= shoot;
            fire_ack  <= accept;
            if (accept)
                cooldownReg <= COOLDOWN_W;
            else if (cooldownReg != 8'd0)
                cooldownReg <= cooldownReg - 8'd1;
        end
    end

    // Allocation looks only at registered flags, so a slot freed this edge waits a cycle.
    assign busyBelow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            slotState_t  stateReg;
            logic [9:0]  xPosReg;
            logic [9:0]  yPosReg;
            logic [4:0]  xSpeedReg;
            logic        xDirReg;
            logic [7:0]  lifeReg;
            logic [10:0] nextX;
            logic        despawn;

            assign activeVec[gi]     = (stateReg == MOVE);
            assign busyBelow[gi + 1] = busyBelow[gi] & activeVec[gi];
            assign grant[gi]         = accept & busyBelow[gi] & ~activeVec[gi];

            // Left underflow wraps to a large 11-bit value and fails the X_MAX test.
            assign nextX   = xDirReg ? ({1'b0, xPosReg} + {6'b0, xSpeedReg})
                                     : ({1'b0, xPosReg} - {6'b0, xSpeedReg});
            assign despawn = (nextX < X_MIN_W) | (nextX > X_MAX_W)
                           | bladeCol[gi] | (lifeReg == LIFE_LAST);

            assign bladeState[27*gi +: 27] = {xPosReg, yPosReg, xSpeedReg, xDirReg, activeVec[gi]};

            always_ff @(posedge sim_clk) begin
                if (!reset_n) begin
                    stateReg  <= IDLE;
                    xPosReg   <= 10'd0;
                    yPosReg   <= 10'd0;
                    xSpeedReg <= 5'd0;
                    xDirReg   <= 1'b0;
                    lifeReg   <= 8'd0;
                end else begin
                    case (stateReg)
                        IDLE: begin
                            if (grant[gi]) begin
                                stateReg  <= MOVE;
                                xPosReg   <= spawnX;
                                yPosReg   <= spawnY;
                                xSpeedReg <= spawnSpeed;
                                xDirReg   <= player_xDir;
                                lifeReg   <= 8'd0;
                            end
                        end
                        MOVE: begin
                            if (despawn) begin
                                stateReg  <= IDLE;
                                xPosReg   <= 10'd0;
                                yPosReg   <= 10'd0;
                                xSpeedReg <= 5'd0;
                                xDirReg   <= 1'b0;
                                lifeReg   <= 8'd0;
                            end else begin
                                xPosReg <= nextX[9:0];
                                lifeReg <= lifeReg + 8'd1;
                            end
                        end
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_blade_pool.sv
// Directed bench for blade_pool: spawn geometry, motion, despawn, allocation,
// cooldown, speed saturation, lifetime and reset.
module tb_blade_pool;

    logic         sim_clk = 1'b0;
    logic         reset_n;
    logic         shoot;
    logic [9:0]   player_xPos;
    logic [9:0]   player_yPos;
    logic [4:0]   player_xSpeed;
    logic         player_xDir;
    logic [3:0]   bladeCol;
    logic [107:0] bladeState;
    logic         fire_ack;
    logic         pool_full;

    int checks = 0;
    int fails  = 0;

    blade_pool dut (
        .sim_clk       (sim_clk),
        .reset_n       (reset_n),
        .shoot         (shoot),
        .player_xPos   (player_xPos),
        .player_yPos   (player_yPos),
        .player_xSpeed (player_xSpeed),
        .player_xDir   (player_xDir),
        .bladeCol      (bladeCol),
        .bladeState    (bladeState),
        .fire_ack      (fire_ack),
        .pool_full     (pool_full)
    );

    always #5 sim_clk = ~sim_clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sim_clk);
            #1;
        end
    endtask

    function automatic logic [26:0] slotOf(input int i);
        return bladeState[27*i +: 27];
    endfunction

    task automatic setPlayer(input logic [9:0] x, input logic [9:0] y,
                             input logic [4:0] s, input logic d);
        player_xPos   = x;
        player_yPos   = y;
        player_xSpeed = s;
        player_xDir   = d;
    endtask

    task automatic doReset;
        reset_n  = 1'b0;
        shoot    = 1'b0;
        bladeCol = 4'b0;
        tick(2);
        reset_n  = 1'b1;
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        shoot    = 1'b0;
        bladeCol = 4'b0;
        setPlayer(10'd400, 10'd300, 5'd3, 1'b1);
        tick(2);
        checks++;
        if (bladeState !== 108'd0) begin
            fails++; $display("FAIL reset_state: got %h expected 0", bladeState);
        end
        checks++;
        if (fire_ack !== 1'b0 || pool_full !== 1'b0) begin
            fails++; $display("FAIL reset_flags: got ack=%b full=%b expected 0 0", fire_ack, pool_full);
        end
        reset_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_fire_right;
        logic [26:0] s;
        doReset();
        setPlayer(10'd400, 10'd300, 5'd3, 1'b1);
        shoot = 1'b1;
        tick(1);
        s = slotOf(0);
        checks++;
        if (s !== {10'd440, 10'd292, 5'd11, 1'b1, 1'b1}) begin
            fails++; $display("FAIL right_spawn: got %h expected %h", s, {10'd440, 10'd292, 5'd11, 1'b1, 1'b1});
        end
        checks++;
        if (fire_ack !== 1'b1) begin
            fails++; $display("FAIL right_ack: got %b expected 1", fire_ack);
        end
        checks++;
        if (bladeState[107:27] !== 81'd0) begin
            fails++; $display("FAIL right_other_slots: got %h expected 0", bladeState[107:27]);
        end
        // shoot stays high: no second shot, ack drops
        tick(1);
        s = slotOf(0);
        checks++;
        if (fire_ack !== 1'b0 || s[26:17] !== 10'd451) begin
            fails++; $display("FAIL right_move1: got ack=%b x=%0d expected 0 451", fire_ack, s[26:17]);
        end
        tick(1);
        s = slotOf(0);
        checks++;
        if (s[26:17] !== 10'd462 || slotOf(1) !== 27'd0) begin
            fails++; $display("FAIL right_move2: got x=%0d slot1=%h expected 462 0", s[26:17], slotOf(1));
        end
        shoot = 1'b0;
        $display("test_fire_right done");
    endtask

    task automatic test_fire_left;
        logic [26:0] s;
        logic [9:0]  ex;
        doReset();
        setPlayer(10'd400, 10'd300, 5'd3, 1'b0);
        shoot = 1'b1;
        tick(1);
        shoot = 1'b0;
        s = slotOf(0);
        checks++;
        if (s !== {10'd332, 10'd292, 5'd11, 1'b0, 1'b1}) begin
            fails++; $display("FAIL left_spawn: got %h expected %h", s, {10'd332, 10'd292, 5'd11, 1'b0, 1'b1});
        end
        for (int k = 1; k <= 17; k++) begin
            tick(1);
            s  = slotOf(0);
            ex = 10'(332 - 11 * k);
            checks++;
            if (s[26:17] !== ex || s[0] !== 1'b1) begin
                fails++; $display("FAIL left_move%0d: got x=%0d act=%b expected %0d 1", k, s[26:17], s[0], ex);
            end
        end
        tick(1);
        checks++;
        if (slotOf(0) !== 27'd0) begin
            fails++; $display("FAIL left_despawn: got %h expected 0", slotOf(0));
        end
        $display("test_fire_left done");
    endtask

    task automatic test_pool_full;
        logic [26:0] s;
        doReset();
        setPlayer(10'd150, 10'd300, 5'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                shoot = 1'b0;
                tick(10);
            end
            shoot = 1'b1;
            tick(1);
            s = slotOf(k);
            checks++;
            if (fire_ack !== 1'b1 || s[0] !== 1'b1) begin
                fails++; $display("FAIL pool_shot%0d: got ack=%b act=%b expected 1 1", k, fire_ack, s[0]);
            end
        end
        checks++;
        if (pool_full !== 1'b1) begin
            fails++; $display("FAIL pool_full_set: got %b expected 1", pool_full);
        end
        shoot = 1'b0;
        tick(10);
        shoot = 1'b1;
        tick(1);
        checks++;
        if (fire_ack !== 1'b0 || pool_full !== 1'b1) begin
            fails++; $display("FAIL pool_reject: got ack=%b full=%b expected 0 1", fire_ack, pool_full);
        end
        // shot in the same cycle slot1 is freed must still be rejected
        shoot = 1'b0;
        tick(1);
        shoot    = 1'b1;
        bladeCol = 4'b0010;
        tick(1);
        s = slotOf(1);
        checks++;
        if (fire_ack !== 1'b0 || s !== 27'd0 || pool_full !== 1'b0) begin
            fails++; $display("FAIL pool_free_same_cycle: got ack=%b slot1=%h full=%b expected 0 0 0", fire_ack, s, pool_full);
        end
        shoot    = 1'b0;
        bladeCol = 4'b0;
        tick(1);
        shoot = 1'b1;
        tick(1);
        s = slotOf(1);
        checks++;
        if (fire_ack !== 1'b1 || s !== {10'd190, 10'd292, 5'd8, 1'b1, 1'b1}) begin
            fails++; $display("FAIL pool_refill: got ack=%b slot1=%h expected 1 %h", fire_ack, s, {10'd190, 10'd292, 5'd8, 1'b1, 1'b1});
        end
        checks++;
        if (pool_full !== 1'b1) begin
            fails++; $display("FAIL pool_full_again: got %b expected 1", pool_full);
        end
        shoot = 1'b0;
        $display("test_pool_full done");
    endtask

    task automatic test_cooldown;
        // accept at edge A, attempts at A+5 and A+10 rejected, A+12 accepted
        doReset();
        setPlayer(10'd200, 10'd300, 5'd0, 1'b1);
        shoot = 1'b1;
        tick(1);
        shoot = 1'b0;
        tick(4);
        shoot = 1'b1;
        tick(1);
        checks++;
        if (fire_ack !== 1'b0 || slotOf(1) !== 27'd0) begin
            fails++; $display("FAIL cd_reject5: got ack=%b slot1=%h expected 0 0", fire_ack, slotOf(1));
        end
        shoot = 1'b0;
        tick(4);
        shoot = 1'b1;
        tick(1);
        checks++;
        if (fire_ack !== 1'b0 || slotOf(1) !== 27'd0) begin
            fails++; $display("FAIL cd_reject10: got ack=%b slot1=%h expected 0 0", fire_ack, slotOf(1));
        end
        shoot = 1'b0;
        tick(1);
        shoot = 1'b1;
        tick(1);
        checks++;
        if (fire_ack !== 1'b1 || slotOf(1) !== {10'd240, 10'd292, 5'd8, 1'b1, 1'b1}) begin
            fails++; $display("FAIL cd_accept12: got ack=%b slot1=%h expected 1 %h", fire_ack, slotOf(1), {10'd240, 10'd292, 5'd8, 1'b1, 1'b1});
        end
        // shoot rising 10 ticks after the accept edge lands exactly as cooldown expires
        doReset();
        shoot = 1'b1;
        tick(1);
        shoot = 1'b0;
        tick(10);
        shoot = 1'b1;
        tick(1);
        checks++;
        if (fire_ack !== 1'b1 || slotOf(1) === 27'd0) begin
            fails++; $display("FAIL cd_accept11: got ack=%b slot1=%h expected 1 active", fire_ack, slotOf(1));
        end
        tick(12);
        checks++;
        if (slotOf(2) !== 27'd0) begin
            fails++; $display("FAIL cd_hold_once: got slot2=%h expected 0", slotOf(2));
        end
        shoot = 1'b0;
        $display("test_cooldown done");
    endtask

    task automatic test_saturate;
        logic [4:0] inSpeed [4];
        logic [4:0] expSpeed [4];
        logic [26:0] s;
        inSpeed  = '{5'd30, 5'd23, 5'd24, 5'd5};
        expSpeed = '{5'd31, 5'd31, 5'd31, 5'd13};
        for (int i = 0; i < 4; i++) begin
            doReset();
            setPlayer(10'd400, 10'd300, inSpeed[i], 1'b1);
            shoot = 1'b1;
            tick(1);
            shoot = 1'b0;
            s = slotOf(0);
            checks++;
            if (s[6:2] !== expSpeed[i]) begin
                fails++; $display("FAIL sat_speed%0d: got %0d expected %0d", inSpeed[i], s[6:2], expSpeed[i]);
            end
        end
        $display("test_saturate done");
    endtask

    task automatic test_lifetime;
        logic [26:0] s;
        doReset();
        setPlayer(10'd150, 10'd300, 5'd0, 1'b1);
        shoot = 1'b1;
        tick(1);
        shoot = 1'b0;
        tick(63);
        s = slotOf(0);
        checks++;
        if (s[0] !== 1'b1 || s[26:17] !== 10'd694) begin
            fails++; $display("FAIL life_last_move: got act=%b x=%0d expected 1 694", s[0], s[26:17]);
        end
        tick(1);
        checks++;
        if (slotOf(0) !== 27'd0) begin
            fails++; $display("FAIL life_expire: got %h expected 0", slotOf(0));
        end
        shoot = 1'b1;
        tick(1);
        shoot = 1'b0;
        checks++;
        if (slotOf(0) === 27'd0) begin
            fails++; $display("FAIL life_respawn: got %h expected active", slotOf(0));
        end
        tick(5);
        reset_n = 1'b0;
        tick(1);
        checks++;
        if (bladeState !== 108'd0 || fire_ack !== 1'b0 || pool_full !== 1'b0) begin
            fails++; $display("FAIL midflight_reset: got %h ack=%b full=%b expected 0 0 0", bladeState, fire_ack, pool_full);
        end
        reset_n = 1'b1;
        $display("test_lifetime done");
    endtask

    task automatic test_accept_and_despawn;
        doReset();
        setPlayer(10'd300, 10'd300, 5'd0, 1'b1);
        shoot = 1'b1;
        tick(1);
        shoot = 1'b0;
        tick(10);
        shoot    = 1'b1;
        bladeCol = 4'b0001;
        tick(1);
        shoot    = 1'b0;
        bladeCol = 4'b0;
        checks++;
        if (slotOf(0) !== 27'd0 || fire_ack !== 1'b1) begin
            fails++; $display("FAIL same_cycle_despawn: got slot0=%h ack=%b expected 0 1", slotOf(0), fire_ack);
        end
        checks++;
        if (slotOf(1) !== {10'd340, 10'd292, 5'd8, 1'b1, 1'b1}) begin
            fails++; $display("FAIL same_cycle_alloc: got %h expected %h", slotOf(1), {10'd340, 10'd292, 5'd8, 1'b1, 1'b1});
        end
        $display("test_accept_and_despawn done");
    endtask

    initial begin
        reset_n  = 1'b0;
        shoot    = 1'b0;
        bladeCol = 4'b0;
        setPlayer(10'd0, 10'd0, 5'd0, 1'b0);
        test_reset();
        test_fire_right();
        test_fire_left();
        test_pool_full();
        test_cooldown();
        test_saturate();
        test_lifetime();
        test_accept_and_despawn();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
